// File: rtl/seg_pkg.sv
// Shared active-low 7-segment patterns {g,f,e,d,c,b,a} for counter-chain display blocks.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10-15 show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_code)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with per-frame input snapshot and leading-zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 4,
  parameter int unsigned REFRESH_DIV = 1000,
  parameter int unsigned DIV_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [N_DIGITS-1:0]   an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned IDX_BITS = $clog2(N_DIGITS);

  logic [DIV_BITS-1:0]   r_div;
  logic [IDX_BITS-1:0]   r_idx;
  logic [4*N_DIGITS-1:0] r_snap_digits;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic                  r_snap_blank;
  logic [N_DIGITS-1:0]   r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;

  logic                  w_tick;
  logic                  w_wrap;
  logic [3:0]            w_code;
  logic                  w_sel_dp;
  logic                  w_sel_blank;
  logic [N_DIGITS-1:0]   w_blank;
  logic                  w_run;
  logic [6:0]            w_dec;

  assign w_tick = (r_div == DIV_BITS'(REFRESH_DIV - 1));
  assign w_wrap = w_tick && (r_idx == IDX_BITS'(N_DIGITS - 1));

  // A digit is blanked only while every digit from the top down to it is zero.
  always_comb begin
    w_blank = '0;
    w_run   = r_snap_blank;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_run      = w_run && (r_snap_digits[4*k +: 4] == 4'd0);
      w_blank[k] = w_run;
    end
  end

  always_comb begin
    w_code      = '0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_BITS'(k)) begin
        w_code      = r_snap_digits[4*k +: 4];
        w_sel_dp    = r_snap_dp[k];
        w_sel_blank = w_blank[k];
      end
    end
  end

  bcd_to_seg u_dec (
    .i_code (w_code),
    .o_seg  (w_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div         <= '0;
      r_idx         <= '0;
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_blank  <= 1'b0;
      r_an          <= '1;
      r_seg         <= SEG_OFF;
      r_dp          <= 1'b1;
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_BITS'(1);
      if (w_tick) begin
        r_idx <= w_wrap ? '0 : r_idx + IDX_BITS'(1);
      end
      if (w_wrap) begin
        r_snap_digits <= digits;
        r_snap_dp     <= dp_in;
        r_snap_blank  <= blank_lz;
      end
      r_an  <= ~(N_DIGITS'(1) << r_idx);
      r_seg <= w_sel_blank ? SEG_OFF : w_dec;
      r_dp  <= w_sel_blank ? 1'b1 : ~w_sel_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, giving the number of multiplexed 7-segment digits (range 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 1000, giving the clock cycles each digit stays selected (at least 2).
REQ-003 SHALL have parameter DIV_BITS, default 16, giving the refresh divider width, with 2**DIV_BITS >= REFRESH_DIV.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port digits, input, 4*N_DIGITS bits: BCD codes from the counter chain; digit k occupies bits [4k+3:4k], and digit 0 is least significant.
REQ-007 SHALL have port dp_in, input, N_DIGITS bits: decimal-point request per digit, active-high.
REQ-008 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 SHALL have port an, output, N_DIGITS bits: digit enables, active-low, one-hot-low or all-high.
REQ-010 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 SHALL have port dp, output, 1 bit: decimal point, active-low.

Function
REQ-012 SHALL keep a divider div counting 0..REFRESH_DIV-1 and wrapping to 0; the cycle with div==REFRESH_DIV-1 is a tick.
REQ-013 SHALL advance a digit index idx by 1 on each tick, wrapping from N_DIGITS-1 to 0; a frame is one full pass of idx.
REQ-014 SHALL load a snapshot register from digits, dp_in and blank_lz on the tick where idx wraps N_DIGITS-1 -> 0, and hold it for the whole frame, so no tearing occurs.
REQ-015 SHALL register an, seg and dp, reflecting idx and the snapshot as of the previous cycle (one-clock latency).
REQ-016 SHALL drive an[idx]=0 with all other an bits 1.
REQ-017 SHALL decode BCD codes 0-9 to the standard patterns (0 -> 7'h40, 1 -> 7'h79, 4 -> 7'h19, 7 -> 7'h78, 8 -> 7'h00).
REQ-018 SHALL decode codes 10-15 to a dash, 7'h3F.
REQ-019 SHALL blank digit k (k>0) when the snapshot blank_lz=1, digit k==0, and every digit above k is also blanked; a blanked digit gets seg=7'h7F and dp=1 while an stays active.
REQ-020 SHALL never blank digit 0.
REQ-021 SHALL drive dp as the inverse of the snapshot dp_in[idx], independent of blanking of non-blanked digits.
REQ-022 SHALL ignore changes on digits, dp_in and blank_lz between snapshot loads.

Reset
REQ-023 SHALL, while reset=1 and regardless of clk, hold div=0, idx=0, snapshot all zero, an all 1, seg=7'h7F and dp=1.
REQ-024 SHALL, on the first rising clk edge after reset deasserts, drive an=~1 (digit 0) and seg=7'h40, displaying the zero snapshot until the first frame wrap.
REQ-025 SHALL abandon a frame when reset asserts mid-frame; no partial-frame state survives.

Structure
REQ-026 SHALL place the segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) in shared package seg_pkg, so counter-chain display blocks reuse them.
REQ-027 SHALL implement the decode in a combinational sub-module bcd_to_seg (4-bit code in, 7-bit active-low pattern out), instantiated once on the selected digit.
REQ-028 SHALL make the divider, index, snapshot and output registers the only state.

Verification (N_DIGITS=4, REFRESH_DIV=4)
REQ-029 SHALL check reset: hold reset high for 10 cycles -> an=4'hF, seg=7'h7F, dp=1; after release, the first edge gives an=4'hE and seg=7'h40.
REQ-030 SHALL check scan order: digits=16'h1234, blank_lz=0, then wait one frame -> an steps E,D,B,7, each held 4 cycles, with seg 7'h19, 7'h30, 7'h24, 7'h79.
REQ-031 SHALL check the snapshot: change digits from 16'h1234 to 16'h9999 mid-frame -> the remaining digits still show 3, 2, 1, and the next frame shows 9s.
REQ-032 SHALL check blanking: digits=16'h0070, blank_lz=1 -> digits 3 and 2 seg=7'h7F with an active, digit 1 seg=7'h78, digit 0 seg=7'h40; with blank_lz=0, digits 3 and 2 show 7'h40.
REQ-033 SHALL check invalid code and dp: digits=16'h00A0, dp_in=4'b0010 -> digit 1 seg=7'h3F and dp=0; all other digits dp=1.
REQ-034 SHALL check reset mid-frame: assert reset at idx=2, div=1 -> outputs go off within the same cycle asynchronously; after release, scanning restarts at digit 0 with div=0.
